// File: rtl/wall_probe_arbiter_if.sv
// Bundles the requester handshake and the wall-ROM port of wall_probe_arbiter.
// The arbiter takes the slave view; the requester/ROM side takes the master view.
interface wall_probe_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [10*NUM_REQ-1:0] req_x;
  logic [10*NUM_REQ-1:0] req_y;
  logic [2*NUM_REQ-1:0]  req_dir;
  logic [NUM_REQ-1:0]    ack;
  logic                  blocked;
  logic                  busy;
  logic                  wall_rd;
  logic [9:0]            wall_x;
  logic [9:0]            wall_y;
  logic                  wall_bit;

  modport slave (
    input  req, req_x, req_y, req_dir, wall_bit,
    output ack, blocked, busy, wall_rd, wall_x, wall_y
  );

  modport master (
    output req, req_x, req_y, req_dir, wall_bit,
    input  ack, blocked, busy, wall_rd, wall_x, wall_y
  );
endinterface

// File: rtl/wall_probe_arbiter.sv
// Round-robin arbiter sharing one wall-map ROM port between sprite movers: two
// leading-edge corner probes per request, answered with a blocked flag and a one-cycle ack.
module wall_probe_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SPRITE_SIZE = 16,
  parameter int ROM_LAT     = 2,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic                Clk,
  input  logic                Reset_n,
  wall_probe_arbiter_if.slave bus
);

  localparam int          GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [10:0] S_W    = 11'(SPRITE_SIZE);
  localparam logic [10:0] XM_W   = 11'(X_MAX);
  localparam logic [10:0] YM_W   = 11'(Y_MAX);
  localparam logic [2:0]  CYC_B0 = 3'(1 + ROM_LAT);
  localparam logic [2:0]  CYC_B1 = 3'(2 + ROM_LAT);

  typedef enum logic [2:0] {IDLE, P0, P1, WAIT, RESP} state_t;

  typedef struct packed {
    logic       oor;
    logic [9:0] x;
    logic [9:0] y;
  } probe_t;

  // 11-bit arithmetic so the screen-edge tests see the carry / borrow.
  function automatic probe_t probe(input logic [9:0] x, input logic [9:0] y,
                                   input logic [1:0] dir, input logic second);
    logic [10:0] px;
    logic [10:0] py;
    logic        oor;
    px  = {1'b0, x};
    py  = {1'b0, y};
    oor = 1'b0;
    case (dir)
      2'b00: begin
        py  = {1'b0, y} - 11'd1;
        oor = (y == 10'd0);
        if (second) px = {1'b0, x} + S_W - 11'd1;
      end
      2'b01: begin
        py  = {1'b0, y} + S_W;
        oor = (py > YM_W);
        if (second) px = {1'b0, x} + S_W - 11'd1;
      end
      2'b10: begin
        px  = {1'b0, x} - 11'd1;
        oor = (x == 10'd0);
        if (second) py = {1'b0, y} + S_W - 11'd1;
      end
      default: begin
        px  = {1'b0, x} + S_W;
        oor = (px > XM_W);
        if (second) py = {1'b0, y} + S_W - 11'd1;
      end
    endcase
    return '{oor: oor, x: px[9:0], y: py[9:0]};
  endfunction

  state_t               state_q;
  logic [GW-1:0]        rr_q;
  logic [GW-1:0]        g_q;
  logic [2:0]           cyc_q;
  logic                 oor0_q;
  logic                 oor1_q;
  logic                 bit0_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 blocked_q;
  logic                 busy_q;
  logic                 wall_rd_q;
  logic [9:0]           wall_x_q;
  logic [9:0]           wall_y_q;
  logic [9:0]           x_q;
  logic [9:0]           y_q;
  logic [1:0]           dir_q;

  logic [GW-1:0]        gnt_d;
  logic                 gnt_vld_d;
  logic [GW:0]          idx_d;
  probe_t               pr0_d;
  probe_t               pr1_d;

  always_comb begin
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    idx_d     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_d = {1'b0, rr_q} + (GW+1)'(k);
      if (idx_d >= (GW+1)'(NUM_REQ)) idx_d = idx_d - (GW+1)'(NUM_REQ);
      if (!gnt_vld_d && bus.req[idx_d[GW-1:0]]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = idx_d[GW-1:0];
      end
    end
  end

  assign pr0_d = probe(bus.req_x[10*gnt_d +: 10], bus.req_y[10*gnt_d +: 10],
                       bus.req_dir[2*gnt_d +: 2], 1'b0);
  assign pr1_d = probe(x_q, y_q, dir_q, 1'b1);

  // Request payload is captured once at grant; no reset needed on pure data.
  always_ff @(posedge Clk) begin
    if (state_q == IDLE && gnt_vld_d) begin
      x_q   <= bus.req_x[10*gnt_d +: 10];
      y_q   <= bus.req_y[10*gnt_d +: 10];
      dir_q <= bus.req_dir[2*gnt_d +: 2];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      g_q       <= '0;
      cyc_q     <= '0;
      oor0_q    <= 1'b0;
      oor1_q    <= 1'b0;
      bit0_q    <= 1'b0;
      ack_q     <= '0;
      blocked_q <= 1'b0;
      busy_q    <= 1'b0;
      wall_rd_q <= 1'b0;
      wall_x_q  <= '0;
      wall_y_q  <= '0;
    end else begin
      ack_q     <= '0;
      blocked_q <= 1'b0;
      if (state_q != IDLE) cyc_q <= cyc_q + 3'd1;
      // Probe 0 answers in cycle 1+ROM_LAT, which may still be P1 when ROM_LAT = 1.
      if ((state_q == P1 || state_q == WAIT) && cyc_q == CYC_B0)
        bit0_q <= bus.wall_bit | oor0_q;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            state_q   <= P0;
            busy_q    <= 1'b1;
            g_q       <= gnt_d;
            cyc_q     <= 3'd1;
            oor0_q    <= pr0_d.oor;
            wall_rd_q <= ~pr0_d.oor;
            wall_x_q  <= pr0_d.x;
            wall_y_q  <= pr0_d.y;
          end
        end
        P0: begin
          state_q   <= P1;
          oor1_q    <= pr1_d.oor;
          wall_rd_q <= ~pr1_d.oor;
          wall_x_q  <= pr1_d.x;
          wall_y_q  <= pr1_d.y;
        end
        P1: begin
          state_q   <= WAIT;
          wall_rd_q <= 1'b0;
        end
        WAIT: begin
          if (cyc_q == CYC_B1) begin
            state_q    <= RESP;
            ack_q[g_q] <= 1'b1;
            blocked_q  <= bit0_q | bus.wall_bit | oor1_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rr_q    <= (g_q == GW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
        end
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.blocked = blocked_q;
  assign bus.busy    = busy_q;
  assign bus.wall_rd = wall_rd_q;
  assign bus.wall_x  = wall_x_q;
  assign bus.wall_y  = wall_y_q;

endmodule

// File: doc/wall_probe_arbiter.md
Name: wall_probe_arbiter

Overview:
- Shares the single-port wall-map ROM between all sprite movers: the player ball and the ghosts.
- Each mover asks whether a one-pixel step in a direction is legal. The block arbitrates round-robin and issues two leading-edge corner probes to the ROM.
- It returns one blocked flag with a one-cycle ack.
- It replaces the per-sprite combinational ValidMove lookups, so one ROM port serves every sprite.

Parameters:
- NUM_REQ, 4, number of requesters (index 0 = player, 1..3 = ghosts).
- SPRITE_SIZE, 16, sprite edge length in pixels.
- ROM_LAT, 2, wall ROM read latency in cycles (legal range 1..4).
- X_MAX, 639, rightmost legal pixel column.
- Y_MAX, 479, bottommost legal pixel row.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_x  in  10*NUM_REQ  sprite top-left X, packed; slice i = bits [10i+9:10i].
- req_y  in  10*NUM_REQ  sprite top-left Y, packed the same way.
- req_dir  in  2*NUM_REQ  direction: 00 up, 01 down, 10 left, 11 right.
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- blocked  out  1  result; valid only while any ack bit is 1.
- busy  out  1  high in every state except IDLE.
- wall_rd  out  1  ROM read strobe.
- wall_x  out  10  probe column.
- wall_y  out  10  probe row.
- wall_bit  in  1  ROM data (1 = wall); valid ROM_LAT cycles after its wall_rd cycle.

Behaviour:
- Reset values: ack = 0, blocked = 0, busy = 0, wall_rd = 0, wall_x = 0, wall_y = 0, rr pointer = 0, state = IDLE.
- Reset is asynchronous and may assert in any state. It aborts the transaction with no ack. In-flight ROM data is ignored after reset.
- States: IDLE -> P0 -> P1 -> WAIT -> RESP -> IDLE.
- IDLE: if any req bit is 1, grant g = first set bit at or after the rr pointer, scanning upward and wrapping.
  - Latch req_x[g], req_y[g], req_dir[g] and g.
  - Go to P0. With no request, stay in IDLE.
- P0 (cycle 1 after the grant edge): drive probe 0. P1 (cycle 2): drive probe 1.
- wall_rd = 1 in each probe cycle unless that probe is out of range.
- Probe points, with S = SPRITE_SIZE:
  - up: (X, Y-1) and (X+S-1, Y-1)
  - down: (X, Y+S) and (X+S-1, Y+S)
  - left: (X-1, Y) and (X-1, Y+S-1)
  - right: (X+S, Y) and (X+S, Y+S-1)
- Arithmetic uses 11-bit unsigned values.
- A probe is out of range when any of these holds: up with Y = 0; left with X = 0; down with Y+S > Y_MAX; right with X+S > X_MAX. For an out-of-range probe:
  - wall_rd = 0 in that cycle.
  - wall_x and wall_y still show the truncated 10-bit value.
  - The probe's bit is forced to 1.
  - Timing is unchanged.
- WAIT: sample wall_bit in cycle 1+ROM_LAT (probe 0) and cycle 2+ROM_LAT (probe 1). Each sample is ORed with its out-of-range flag.
- RESP (cycle 3+ROM_LAT): ack[g] = 1 and blocked = bit0 | bit1 for exactly one cycle. Then:
  - rr pointer = (g+1) mod NUM_REQ.
  - Next cycle returns to IDLE.
- Per-transaction cycle counts:
  - Grant to ack latency = ROM_LAT+3 cycles.
  - Minimum period between grants = ROM_LAT+4 cycles.
- Inputs are latched at grant. Changes to x/y/dir or a dropped req after grant do not affect the transaction, and the ack is still pulsed.
- A req still high in IDLE after its ack is treated as a new request. It competes after the other requesters because of the rr pointer.
- Simultaneous requests: exactly one grant per IDLE visit. There is no starvation: every asserted requester is served within NUM_REQ transactions.
- Outside P0/P1, wall_rd = 0; wall_x and wall_y hold their last value.
- Outside RESP, blocked = 0.

Test Plan:
- Reset then idle: Reset_n low for 3 cycles, req = 0 -> all outputs 0 and busy = 0 for 20 cycles.
- Single legal move: req[0] = 1, X = 314, Y = 209, dir = right, ROM returns 0 -> probes (330,209) and (330,224) in cycles 1 and 2; ack[0] in cycle 5 (ROM_LAT = 2); blocked = 0.
- Wall hit on second probe only: dir = down, X = 100, Y = 100; ROM returns 1 only for (115,116) -> probe 0 = (100,116), probe 1 = (115,116); blocked = 1.
- Screen edge: dir = up, Y = 0 -> wall_rd stays 0 in both probe cycles; blocked = 1; ack still at cycle 5. Repeat with dir = right, X = 624 -> X+S = 640 > 639, so blocked = 1 with no ROM read.
- Round-robin fairness: req = 4'b1111 held constantly -> ack order 0,1,2,3,0 with grants 6 cycles apart. Then req = 4'b1001 with pointer at 1 -> grant 3 before 0.
- Reset mid-transaction: assert Reset_n low during WAIT -> no ack pulse, pointer = 0. After release with req = 4'b0010, requester 1 is served normally.
